// File: rtl/frontmon_mode_sched.sv
`timescale 1ns/1ps
// Purpose : sequences the front-panel monitor mux through its legal mode codes and snapshots MULTOUT once per dwell.
// Latency : SCAN_EN rise to first MODECODE is 2 cycles; the first snapshot lands 2+SETTLE_CYC+max(DWELL,1)+1 cycles after SCAN_EN rise.
// Backpressure : none; the scan never stalls. An unread snapshot is overwritten and flagged by the sticky OVERRUN.
//
// Ports:
//   CLK, RST           clock, asynchronous active-high reset
//   SCAN_EN            run the automatic scan
//   MAN_SEL, MAN_MODE  manual override: pin MAN_MODE (0 if the code is not legal)
//   MODE_MASK          bit n enables mode code n; only legal codes {1..7,9,11,14} count
//   DWELL              valid cycles per mode before capture (0 behaves as 1)
//   MULTOUT            monitored mux output (bit 0 here is schematic bit 1)
//   SNAP_ACK, CLR_OVR  snapshot consumed / clear the sticky overrun
//   MODECODE           mode select to the mux (bit 0 here is schematic bit 1)
//   MODE_VALID         MULTOUT is settled for the current MODECODE
//   SNAP_DATA/MODE/RDY captured word, its mode code, snapshot pending
//   OVERRUN            sticky: a pending snapshot was overwritten
//   OVR_COUNT          saturating overrun count, present only with FRONTMON_SCHED_OVRCNT_EN defined
//   BUSY               sequencer is not idle
// SETTLE_CYC must be in 1..15.
module frontmon_mode_sched #(
  parameter int SETTLE_CYC = 4,
  parameter int DWELL_W    = 8
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               SCAN_EN,
  input  logic               MAN_SEL,
  input  logic [3:0]         MAN_MODE,
  input  logic [15:0]        MODE_MASK,
  input  logic [DWELL_W-1:0] DWELL,
  input  logic [15:0]        MULTOUT,
  input  logic               SNAP_ACK,
  input  logic               CLR_OVR,
  output logic [3:0]         MODECODE,
  output logic               MODE_VALID,
  output logic [15:0]        SNAP_DATA,
  output logic [3:0]         SNAP_MODE,
  output logic               SNAP_RDY,
  output logic               OVERRUN,
`ifdef FRONTMON_SCHED_OVRCNT_EN
  output logic [7:0]         OVR_COUNT,
`endif
  output logic               BUSY
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SWITCH,
    ST_SETTLE,
    ST_DWELL,
    ST_CAPTURE,
    ST_MANUAL
  } state_t;

  // Codes the mux actually implements: 1..7, 9, 11, 14.
  localparam logic [15:0] LEGAL_MASK = 16'h4AFE;
  localparam logic [3:0]  SETTLE_LD  = 4'(SETTLE_CYC - 1);

  state_t               state, state_nxt;
  logic [3:0]           code_nxt;
  logic                 valid_nxt;
  // set_cnt counts down the settle window; it also tracks settling outside
  // the scan so MANUAL can raise MODE_VALID after a code change.
  logic [3:0]           set_cnt, set_cnt_nxt;
  logic [DWELL_W-1:0]   dwl_cnt, dwl_cnt_nxt;
  logic [15:0]          em;
  logic [3:0]           man_code;
  logic                 scan_state;
  logic                 capture;
  logic                 ack;
  logic                 ovr_evt;

  // Next enabled code strictly after cur, wrapping 15 -> 1. With cur == 0
  // this yields the lowest enabled code; with a single enabled code it
  // returns that code again. Returns 0 only when em is empty.
  function automatic logic [3:0] next_code(input logic [3:0] cur, input logic [15:0] mask);
    logic [3:0] res;
    logic [4:0] cand;
    res = 4'd0;
    // Walk from farthest to nearest so the nearest match is kept.
    for (int i = 15; i >= 1; i--) begin
      cand = {1'b0, cur} + 5'(i);
      if (cand > 5'd15) cand = cand - 5'd15;
      if (mask[cand[3:0]]) res = cand[3:0];
    end
    return res;
  endfunction

  assign em         = MODE_MASK & LEGAL_MASK;
  assign man_code   = LEGAL_MASK[MAN_MODE] ? MAN_MODE : 4'd0;
  assign scan_state = (state == ST_SWITCH) || (state == ST_SETTLE) ||
                      (state == ST_DWELL)  || (state == ST_CAPTURE);

  always_comb begin
    state_nxt   = state;
    code_nxt    = MODECODE;
    valid_nxt   = MODE_VALID;
    set_cnt_nxt = set_cnt;
    dwl_cnt_nxt = dwl_cnt;
    capture     = 1'b0;

    if (MAN_SEL) begin
      state_nxt = ST_MANUAL;
      code_nxt  = man_code;
      if (man_code != MODECODE) begin
        set_cnt_nxt = SETTLE_LD;
        valid_nxt   = 1'b0;
      end else if (set_cnt == 4'd0) begin
        valid_nxt = 1'b1;
      end else begin
        set_cnt_nxt = set_cnt - 4'd1;
        valid_nxt   = 1'b0;
      end
    end else if ((state == ST_MANUAL) || (scan_state && !SCAN_EN)) begin
      // Abort: partial dwell is dropped, snapshot registers are untouched.
      state_nxt = ST_IDLE;
      code_nxt  = 4'd0;
      valid_nxt = 1'b0;
      if (MODECODE != 4'd0) set_cnt_nxt = SETTLE_LD;
    end else begin
      case (state)
        ST_IDLE: begin
          valid_nxt = 1'b0;
          if (set_cnt != 4'd0) set_cnt_nxt = set_cnt - 4'd1;
          if (SCAN_EN && (em != 16'd0)) state_nxt = ST_SWITCH;
        end
        ST_SWITCH: begin
          // MODE_VALID is left alone here: MODECODE has not moved yet.
          if (em == 16'd0) begin
            state_nxt = ST_IDLE;
            code_nxt  = 4'd0;
            valid_nxt = 1'b0;
            if (MODECODE != 4'd0) set_cnt_nxt = SETTLE_LD;
          end else begin
            state_nxt   = ST_SETTLE;
            code_nxt    = next_code(MODECODE, em);
            valid_nxt   = 1'b0;
            // Reload even when the code repeats so a single-mode scan still settles.
            set_cnt_nxt = SETTLE_LD;
          end
        end
        ST_SETTLE: begin
          if (set_cnt == 4'd0) begin
            state_nxt   = ST_DWELL;
            valid_nxt   = 1'b1;
            dwl_cnt_nxt = (DWELL == '0) ? '0 : DWELL - DWELL_W'(1);
          end else begin
            set_cnt_nxt = set_cnt - 4'd1;
          end
        end
        ST_DWELL: begin
          if (dwl_cnt == '0) state_nxt = ST_CAPTURE;
          else               dwl_cnt_nxt = dwl_cnt - DWELL_W'(1);
        end
        ST_CAPTURE: begin
          capture   = 1'b1;
          state_nxt = ST_SWITCH;
        end
        default: begin
          state_nxt = ST_IDLE;
          code_nxt  = 4'd0;
          valid_nxt = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state      <= ST_IDLE;
      MODECODE   <= 4'd0;
      MODE_VALID <= 1'b0;
      BUSY       <= 1'b0;
      set_cnt    <= 4'd0;
      dwl_cnt    <= '0;
    end else begin
      state      <= state_nxt;
      MODECODE   <= code_nxt;
      MODE_VALID <= valid_nxt;
      BUSY       <= (state_nxt != ST_IDLE);
      set_cnt    <= set_cnt_nxt;
      dwl_cnt    <= dwl_cnt_nxt;
    end
  end

  // A capture that meets an unacknowledged snapshot is an overrun; an ack in
  // the same cycle as the capture counts as a clean hand-over.
  assign ack     = SNAP_ACK & SNAP_RDY;
  assign ovr_evt = capture & SNAP_RDY & ~SNAP_ACK;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      SNAP_DATA <= 16'd0;
      SNAP_MODE <= 4'd0;
      SNAP_RDY  <= 1'b0;
      OVERRUN   <= 1'b0;
    end else begin
      if (capture) begin
        SNAP_DATA <= MULTOUT;
        SNAP_MODE <= MODECODE;
        SNAP_RDY  <= 1'b1;
      end else if (ack) begin
        SNAP_RDY  <= 1'b0;
      end
      // A new overrun beats a simultaneous clear.
      if (ovr_evt)      OVERRUN <= 1'b1;
      else if (CLR_OVR) OVERRUN <= 1'b0;
    end
  end

`ifdef FRONTMON_SCHED_OVRCNT_EN
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      OVR_COUNT <= 8'd0;
    end else if (ovr_evt) begin
      if (OVR_COUNT != 8'hFF) OVR_COUNT <= OVR_COUNT + 8'd1;
    end else if (CLR_OVR) begin
      OVR_COUNT <= 8'd0;
    end
  end
`endif

endmodule

// File: tb/tb_frontmon_mode_sched.sv
`timescale 1ns/1ps
// Purpose : directed self-checking bench for frontmon_mode_sched (SETTLE_CYC=4).
// Latency : all checks are taken 1ns after the rising edge that produced them.
// Backpressure : SNAP_ACK is driven explicitly per scenario.
module tb_frontmon_mode_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic        scan_en;
  logic        man_sel;
  logic [3:0]  man_mode;
  logic [15:0] mode_mask;
  logic [7:0]  dwell;
  logic [15:0] multout;
  logic        snap_ack;
  logic        clr_ovr;
  logic [3:0]  modecode;
  logic        mode_valid;
  logic [15:0] snap_data;
  logic [3:0]  snap_mode;
  logic        snap_rdy;
  logic        overrun;
  logic        busy;
`ifdef FRONTMON_SCHED_OVRCNT_EN
  logic [7:0]  ovr_count;
`endif

  // Mux model: either echo the selected code in the low nibble, or a fixed word.
  logic        mux_follow;
  logic [15:0] mult_val;
  assign multout = mux_follow ? {12'hC30, modecode} : mult_val;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  frontmon_mode_sched #(.SETTLE_CYC(4), .DWELL_W(8)) dut (
    .CLK        (clk),
    .RST        (rst),
    .SCAN_EN    (scan_en),
    .MAN_SEL    (man_sel),
    .MAN_MODE   (man_mode),
    .MODE_MASK  (mode_mask),
    .DWELL      (dwell),
    .MULTOUT    (multout),
    .SNAP_ACK   (snap_ack),
    .CLR_OVR    (clr_ovr),
    .MODECODE   (modecode),
    .MODE_VALID (mode_valid),
    .SNAP_DATA  (snap_data),
    .SNAP_MODE  (snap_mode),
    .SNAP_RDY   (snap_rdy),
    .OVERRUN    (overrun),
`ifdef FRONTMON_SCHED_OVRCNT_EN
    .OVR_COUNT  (ovr_count),
`endif
    .BUSY       (busy)
  );

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic bit is_legal(input logic [3:0] c);
    case (c)
      4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd9, 4'd11, 4'd14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic test_reset();
    rst = 1'b1; scan_en = 1'b0; man_sel = 1'b0; man_mode = 4'd0; mode_mask = 16'd0;
    dwell = 8'd0; snap_ack = 1'b0; clr_ovr = 1'b0; mux_follow = 1'b0; mult_val = 16'd0;
    tick(2);
    total++; if (modecode !== 4'd0) begin bad++; $display("FAIL reset_modecode got=%0d exp=0", modecode); end
    total++; if (mode_valid !== 1'b0) begin bad++; $display("FAIL reset_mode_valid got=%b exp=0", mode_valid); end
    total++; if (snap_data !== 16'd0) begin bad++; $display("FAIL reset_snap_data got=%h exp=0000", snap_data); end
    total++; if (snap_mode !== 4'd0) begin bad++; $display("FAIL reset_snap_mode got=%0d exp=0", snap_mode); end
    total++; if (snap_rdy !== 1'b0) begin bad++; $display("FAIL reset_snap_rdy got=%b exp=0", snap_rdy); end
    total++; if (overrun !== 1'b0) begin bad++; $display("FAIL reset_overrun got=%b exp=0", overrun); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    rst = 1'b0;
    tick(1);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL idle_busy got=%b exp=0", busy); end
  endtask

  task automatic test_scan_all();
    logic [3:0] exp_seq [0:10] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd9, 4'd11, 4'd14, 4'd1};
    bit illegal_seen = 1'b0;
    mode_mask = 16'hFFFF; dwell = 8'd3; mux_follow = 1'b1; scan_en = 1'b1;
    tick(2);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL scan_busy got=%b exp=1", busy); end
    for (int k = 0; k < 11; k++) begin
      total++; if (modecode !== exp_seq[k]) begin bad++; $display("FAIL scan_code[%0d] got=%0d exp=%0d", k, modecode, exp_seq[k]); end
      total++; if (mode_valid !== 1'b0) begin bad++; $display("FAIL scan_valid_lo[%0d] got=%b exp=0", k, mode_valid); end
      if (k < 10) begin
        for (int j = 1; j <= 8; j++) begin
          tick(1);
          if (!is_legal(modecode)) illegal_seen = 1'b1;
          if (j == 3) begin
            total++; if (mode_valid !== 1'b0) begin bad++; $display("FAIL scan_settle_end[%0d] got=%b exp=0", k, mode_valid); end
          end
          if (j == 4) begin
            total++; if (mode_valid !== 1'b1) begin bad++; $display("FAIL scan_valid_hi[%0d] got=%b exp=1", k, mode_valid); end
          end
        end
        total++; if (snap_rdy !== 1'b1) begin bad++; $display("FAIL scan_snap_rdy[%0d] got=%b exp=1", k, snap_rdy); end
        total++; if (snap_mode !== exp_seq[k]) begin bad++; $display("FAIL scan_snap_mode[%0d] got=%0d exp=%0d", k, snap_mode, exp_seq[k]); end
        total++; if (snap_data !== {12'hC30, exp_seq[k]}) begin bad++; $display("FAIL scan_snap_data[%0d] got=%h exp=%h", k, snap_data, {12'hC30, exp_seq[k]}); end
        snap_ack = 1'b1;
        tick(1);
        snap_ack = 1'b0;
        total++; if (snap_rdy !== 1'b0) begin bad++; $display("FAIL scan_ack_clr[%0d] got=%b exp=0", k, snap_rdy); end
      end
    end
    total++; if (illegal_seen !== 1'b0) begin bad++; $display("FAIL scan_illegal_code got=%b exp=0", illegal_seen); end
    // Drop SCAN_EN during SETTLE of the wrapped code 1.
    scan_en = 1'b0;
    tick(1);
    total++; if (modecode !== 4'd0) begin bad++; $display("FAIL stop_modecode got=%0d exp=0", modecode); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL stop_busy got=%b exp=0", busy); end
    total++; if (snap_mode !== 4'd14) begin bad++; $display("FAIL stop_snap_kept got=%0d exp=14", snap_mode); end
  endtask

  task automatic test_single_mode();
    int lowcnt;
    mux_follow = 1'b0; mult_val = 16'hA5C3; mode_mask = 16'h0200; dwell = 8'd3; scan_en = 1'b1;
    tick(2);
    for (int p = 0; p < 2; p++) begin
      lowcnt = 0;
      for (int j = 0; j < 9; j++) begin
        if (j == 0) begin
          total++; if (modecode !== 4'd9) begin bad++; $display("FAIL single_code[%0d] got=%0d exp=9", p, modecode); end
        end
        if (mode_valid === 1'b0) lowcnt++;
        if (j == 8) begin
          total++; if (snap_rdy !== 1'b1) begin bad++; $display("FAIL single_rdy[%0d] got=%b exp=1", p, snap_rdy); end
          total++; if (snap_data !== 16'hA5C3) begin bad++; $display("FAIL single_data[%0d] got=%h exp=a5c3", p, snap_data); end
          snap_ack = 1'b1;
        end
        tick(1);
        snap_ack = 1'b0;
      end
      total++; if (lowcnt !== 4) begin bad++; $display("FAIL single_low_cycles[%0d] got=%0d exp=4", p, lowcnt); end
    end
    total++; if (modecode !== 4'd9) begin bad++; $display("FAIL single_reselect got=%0d exp=9", modecode); end
    scan_en = 1'b0;
    tick(1);
  endtask

  task automatic test_overrun();
    mode_mask = 16'h0002; dwell = 8'd0; mux_follow = 1'b0; mult_val = 16'h1111; scan_en = 1'b1;
    tick(7);
    total++; if (snap_rdy !== 1'b0) begin bad++; $display("FAIL dwell0_early got=%b exp=0", snap_rdy); end
    tick(1);
    total++; if (snap_rdy !== 1'b1) begin bad++; $display("FAIL dwell0_first_rdy got=%b exp=1", snap_rdy); end
    total++; if (snap_data !== 16'h1111) begin bad++; $display("FAIL ovr_first_data got=%h exp=1111", snap_data); end
    total++; if (overrun !== 1'b0) begin bad++; $display("FAIL ovr_first_flag got=%b exp=0", overrun); end
    mult_val = 16'h2222;
    tick(7);
    total++; if (overrun !== 1'b1) begin bad++; $display("FAIL ovr_set got=%b exp=1", overrun); end
    total++; if (snap_data !== 16'h2222) begin bad++; $display("FAIL ovr_latest_data got=%h exp=2222", snap_data); end
    clr_ovr = 1'b1;
    tick(1);
    clr_ovr = 1'b0;
    total++; if (overrun !== 1'b0) begin bad++; $display("FAIL ovr_clear got=%b exp=0", overrun); end
    mult_val = 16'h3333;
    tick(5);
    snap_ack = 1'b1;
    tick(1);
    snap_ack = 1'b0;
    total++; if (snap_rdy !== 1'b1) begin bad++; $display("FAIL ack_cap_rdy got=%b exp=1", snap_rdy); end
    total++; if (snap_data !== 16'h3333) begin bad++; $display("FAIL ack_cap_data got=%h exp=3333", snap_data); end
    total++; if (overrun !== 1'b0) begin bad++; $display("FAIL ack_cap_no_ovr got=%b exp=0", overrun); end
    tick(6);
    clr_ovr = 1'b1;
    tick(1);
    clr_ovr = 1'b0;
    total++; if (overrun !== 1'b1) begin bad++; $display("FAIL ovr_set_beats_clr got=%b exp=1", overrun); end
    snap_ack = 1'b1;
    tick(1);
    snap_ack = 1'b0;
    total++; if (snap_rdy !== 1'b0) begin bad++; $display("FAIL ovr_ack_clr got=%b exp=0", snap_rdy); end
    scan_en = 1'b0; clr_ovr = 1'b1;
    tick(1);
    clr_ovr = 1'b0;
    total++; if (overrun !== 1'b0) begin bad++; $display("FAIL ovr_final_clr got=%b exp=0", overrun); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL ovr_idle_busy got=%b exp=0", busy); end
  endtask

  task automatic test_manual();
    mode_mask = 16'h0024; dwell = 8'd3; mux_follow = 1'b1; scan_en = 1'b1;
    tick(2);
    total++; if (modecode !== 4'd2) begin bad++; $display("FAIL man_pre_code got=%0d exp=2", modecode); end
    tick(5);
    total++; if (mode_valid !== 1'b1) begin bad++; $display("FAIL man_pre_dwell got=%b exp=1", mode_valid); end
    man_sel = 1'b1; man_mode = 4'd14;
    tick(1);
    total++; if (modecode !== 4'd14) begin bad++; $display("FAIL man_code14 got=%0d exp=14", modecode); end
    total++; if (mode_valid !== 1'b0) begin bad++; $display("FAIL man_valid_drop got=%b exp=0", mode_valid); end
    tick(3);
    total++; if (mode_valid !== 1'b0) begin bad++; $display("FAIL man_valid_early got=%b exp=0", mode_valid); end
    tick(1);
    total++; if (mode_valid !== 1'b1) begin bad++; $display("FAIL man_valid_rise got=%b exp=1", mode_valid); end
    tick(10);
    total++; if (snap_rdy !== 1'b0) begin bad++; $display("FAIL man_no_capture got=%b exp=0", snap_rdy); end
    total++; if (modecode !== 4'd14) begin bad++; $display("FAIL man_hold got=%0d exp=14", modecode); end
    man_mode = 4'd8;
    tick(1);
    total++; if (modecode !== 4'd0) begin bad++; $display("FAIL man_illegal got=%0d exp=0", modecode); end
    man_sel = 1'b0;
    tick(1);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL man_exit_busy got=%b exp=0", busy); end
    tick(2);
    total++; if (modecode !== 4'd2) begin bad++; $display("FAIL man_restart got=%0d exp=2", modecode); end
    scan_en = 1'b0; man_mode = 4'd0;
    tick(1);
  endtask

  task automatic test_idle_cases();
    mode_mask = 16'h0101; dwell = 8'd3; mux_follow = 1'b1; scan_en = 1'b1;
    tick(3);
    total++; if (modecode !== 4'd0) begin bad++; $display("FAIL em0_code got=%0d exp=0", modecode); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL em0_busy got=%b exp=0", busy); end
    mode_mask = 16'h0002;
    tick(2);
    total++; if (modecode !== 4'd1) begin bad++; $display("FAIL maskchg_start got=%0d exp=1", modecode); end
    mode_mask = 16'h0000;
    tick(8);
    total++; if (snap_rdy !== 1'b1) begin bad++; $display("FAIL maskchg_dwell_done got=%b exp=1", snap_rdy); end
    total++; if (snap_mode !== 4'd1) begin bad++; $display("FAIL maskchg_snap_mode got=%0d exp=1", snap_mode); end
    snap_ack = 1'b1;
    tick(1);
    snap_ack = 1'b0;
    total++; if (modecode !== 4'd0) begin bad++; $display("FAIL maskchg_idle_code got=%0d exp=0", modecode); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL maskchg_idle_busy got=%b exp=0", busy); end
    scan_en = 1'b0;
    tick(1);
  endtask

  task automatic test_reset_mid();
    mode_mask = 16'h0008; dwell = 8'd3; mux_follow = 1'b1; scan_en = 1'b1;
    tick(10);
    total++; if (snap_rdy !== 1'b1) begin bad++; $display("FAIL rmid_rdy got=%b exp=1", snap_rdy); end
    tick(9);
    total++; if (overrun !== 1'b1) begin bad++; $display("FAIL rmid_ovr got=%b exp=1", overrun); end
    tick(5);
    total++; if (mode_valid !== 1'b1) begin bad++; $display("FAIL rmid_in_dwell got=%b exp=1", mode_valid); end
    rst = 1'b1;
    #1;
    total++; if (modecode !== 4'd0) begin bad++; $display("FAIL rmid_modecode got=%0d exp=0", modecode); end
    total++; if (mode_valid !== 1'b0) begin bad++; $display("FAIL rmid_valid got=%b exp=0", mode_valid); end
    total++; if (snap_data !== 16'd0) begin bad++; $display("FAIL rmid_snap_data got=%h exp=0000", snap_data); end
    total++; if (snap_mode !== 4'd0) begin bad++; $display("FAIL rmid_snap_mode got=%0d exp=0", snap_mode); end
    total++; if (snap_rdy !== 1'b0) begin bad++; $display("FAIL rmid_snap_rdy got=%b exp=0", snap_rdy); end
    total++; if (overrun !== 1'b0) begin bad++; $display("FAIL rmid_overrun got=%b exp=0", overrun); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rmid_busy got=%b exp=0", busy); end
    scan_en = 1'b0;
    tick(1);
    rst = 1'b0;
    tick(1);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rmid_post_busy got=%b exp=0", busy); end
  endtask

`ifdef FRONTMON_SCHED_OVRCNT_EN
  task automatic test_ovr_count();
    mode_mask = 16'h0002; dwell = 8'd0; mux_follow = 1'b0; mult_val = 16'h0F0F; scan_en = 1'b1;
    tick(8 + 7 * 5);
    total++; if (ovr_count !== 8'd5) begin bad++; $display("FAIL ovrcnt_5 got=%0d exp=5", ovr_count); end
    tick(7 * 295);
    total++; if (ovr_count !== 8'hFF) begin bad++; $display("FAIL ovrcnt_sat got=%h exp=ff", ovr_count); end
    total++; if (overrun !== 1'b1) begin bad++; $display("FAIL ovrcnt_flag got=%b exp=1", overrun); end
    clr_ovr = 1'b1;
    tick(1);
    clr_ovr = 1'b0;
    total++; if (ovr_count !== 8'd0) begin bad++; $display("FAIL ovrcnt_clr got=%h exp=00", ovr_count); end
    scan_en = 1'b0; snap_ack = 1'b1;
    tick(1);
    snap_ack = 1'b0;
    tick(1);
  endtask
`endif

  initial begin
    test_reset();
    test_scan_all();
    test_single_mode();
    test_overrun();
    test_manual();
    test_idle_cases();
    test_reset_mid();
`ifdef FRONTMON_SCHED_OVRCNT_EN
    test_ovr_count();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog_timeout total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule

// File: doc/frontmon_mode_sched.md
Name: frontmon_mode_sched

Overview:
- Sequencer for the front-panel monitor multiplexer.
- Steps MODECODE through a programmable set of legal monitor modes and waits a settle time after each switch.
- Holds each mode for a programmable dwell, then snapshots the 16-bit MULTOUT word into a capture register.
- Capture register is read through a ready/ack handshake by the VME/status logic. A manual override pins a single mode for bench or scope use.

Parameters:
SETTLE_CYC, 4, cycles MODE_VALID stays low after every MODECODE change (mux and output-enable settling); legal range 1..15
DWELL_W, 8, width of DWELL input

Ports:
CLK  in  1  system clock
RST  in  1  asynchronous active-high reset
SCAN_EN  in  1  enable automatic mode scan
MAN_SEL  in  1  manual override select
MAN_MODE  in  4  mode code used while MAN_SEL=1
MODE_MASK  in  16  bit n enables mode code n in scan
DWELL  in  DWELL_W  valid cycles per mode before capture; 0 treated as 1
MULTOUT  in  16  mux output being monitored, bits [16:1]
SNAP_ACK  in  1  consumer has read snapshot
CLR_OVR  in  1  clear OVERRUN
MODECODE  out  4  mode select to mux, bits [4:1]
MODE_VALID  out  1  MULTOUT stable for current MODECODE
SNAP_DATA  out  16  captured MULTOUT, bits [16:1]
SNAP_MODE  out  4  MODECODE at capture
SNAP_RDY  out  1  snapshot pending
OVERRUN  out  1  sticky: snapshot overwritten unread
BUSY  out  1  state != IDLE

Behaviour:
- Reset: all outputs 0. State IDLE.
- Legal codes are L = {1..7, 9, 11, 14}. Effective mask EM = MODE_MASK & 16'h4AFE. Bit 0 and illegal codes are never driven.
- All outputs are registered.
- States:
  - IDLE: MODECODE=0, MODE_VALID=0. Go to SWITCH when SCAN_EN=1, MAN_SEL=0 and EM!=0.
  - SWITCH (1 cycle): load MODECODE with the next EM code strictly after the current one, wrapping 15→1. Entry from IDLE selects the lowest EM code. If EM=0 at this point, go to IDLE.
  - SETTLE: SETTLE_CYC cycles, MODE_VALID=0.
  - DWELL: MODE_VALID=1 for max(DWELL,1) cycles. DWELL is sampled on SETTLE exit.
  - CAPTURE (1 cycle): SNAP_DATA<=MULTOUT, SNAP_MODE<=MODECODE, SNAP_RDY<=1, MODE_VALID stays 1. Then go to SWITCH.
  - MANUAL: MODECODE=MAN_MODE if MAN_MODE is in L, else 0. MODE_VALID is high after SETTLE_CYC cycles since the last MODECODE change. No captures occur.
- Transitions:
  - MAN_SEL=1 from any state enters MANUAL next cycle.
  - MAN_SEL falling goes to IDLE.
  - SCAN_EN=0 in any scan state goes to IDLE next cycle with MODECODE=0. The partial dwell is discarded; SNAP_* are retained.
- Latency: SCAN_EN rise to first MODECODE is 2 cycles. First SNAP_RDY rises 2+SETTLE_CYC+max(DWELL,1)+1 cycles after SCAN_EN rise.
- Period per mode = 1+SETTLE_CYC+max(DWELL,1)+1 cycles.
- Single enabled mode: the same code is reselected every period and MODE_VALID still drops for SETTLE.
- Mask change mid-scan takes effect at the next SWITCH. The current dwell completes even if its code was removed.
- Handshake:
  - SNAP_ACK with SNAP_RDY=1 clears SNAP_RDY next cycle.
  - CAPTURE with SNAP_RDY=1 and no ACK that cycle overwrites data and sets OVERRUN.
  - CAPTURE and ACK in the same cycle: new data is loaded, SNAP_RDY stays 1, no overrun.
  - SNAP_ACK with SNAP_RDY=0 is ignored.
- OVERRUN clears on CLR_OVR or RST. A set event in the same cycle as CLR_OVR wins.
- Reset mid-operation: immediate return to IDLE, all outputs 0, pending snapshot lost.

Optional Feature:
FRONTMON_SCHED_OVRCNT_EN
- Defined: adds output OVR_COUNT[7:0], which increments on every overrun event, saturates at 8'hFF, and clears with OVERRUN (CLR_OVR or RST).
- Undefined: port and counter absent; OVERRUN flag only.

Test Plan:
- MODE_MASK=16'hFFFF, SETTLE_CYC=4, DWELL=3, ACK each SNAP_RDY -> MODECODE sequence 1,2,3,4,5,6,7,9,11,14,1; period 9 cycles; SNAP_MODE matches; 0, 8, 10, 12, 13, 15 never appear.
- MODE_MASK=16'h0200, MULTOUT driven 16'hA5C3 -> MODECODE=9 repeatedly, MODE_VALID low 4 cycles each period, SNAP_DATA=16'hA5C3.
- No SNAP_ACK for 2 captures -> OVERRUN=1, SNAP_DATA holds the latest word; ACK and capture in the same cycle -> SNAP_RDY stays 1, OVERRUN unchanged; CLR_OVR -> OVERRUN=0.
- MAN_SEL=1, MAN_MODE=14 mid-dwell -> MODECODE=14 next cycle, MODE_VALID after 4 cycles, no SNAP_RDY; MAN_MODE=8 -> MODECODE=0; MAN_SEL=0 -> scan restarts at lowest enabled code.
- SCAN_EN drop mid-SETTLE, then MODE_MASK=0 with SCAN_EN=1, then RST mid-DWELL -> IDLE with MODECODE=0 in every case; BUSY=0; after RST all outputs 0.
- With FRONTMON_SCHED_OVRCNT_EN, force 300 overruns -> OVR_COUNT=8'hFF; CLR_OVR -> 0.
